uart_wb_host: RTL

- Wishbone-side host that drives the uart block's bus port.
- Turns three local requests into correctly sequenced uart bus cycles:
  - a byte stream to transmit (valid/ready);
  - single-shot RX read requests;
  - frequency-divider loads.
- Sits between the CPU/command logic and the uart, so no client ever toggles wb_clk/wb_stb by hand.
- Adds arbitration, an ack timeout and a post-reset divider programming cycle.

---
 rtl/uart_wb_host_if.sv | 21 ++
 rtl/uart_wb_host.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_host_if.sv
// Bus bundle between the Wishbone-side host and the uart register port.
// wb_we follows the uart polarity: low writes, high reads.
interface uart_wb_host_if;
  logic [1:0] wb_addr;
  logic [7:0] wb_dout;
  logic [7:0] wb_din;
  logic       wb_we;
  logic       wb_clk;
  logic       wb_stb;
  logic       wb_ack;

  modport master (
    output wb_addr, wb_dout, wb_we, wb_clk, wb_stb,
    input  wb_din, wb_ack
  );

  modport slave (
    input  wb_addr, wb_dout, wb_we, wb_clk, wb_stb,
    output wb_din, wb_ack
  );
endinterface

// File: rtl/uart_wb_host.sv
// Host that sequences TX writes, RX reads and divider loads onto the uart bus,
// with DIV-first arbitration, TX/RX round-robin, ack timeout and a post-reset divider write.
module uart_wb_host #(
  parameter int RESET_DIV   = 78,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  input  logic                  rx_req,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  div_load,
  input  logic [7:0]            div_value,
  output logic                  busy,
  output logic                  err_timeout,
  uart_wb_host_if.master        wb
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_INIT, K_DIV, K_TX, K_RX
  } kind_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RESET_DIV_B  = 8'(RESET_DIV);

  state_t     state;
  kind_t      kind;
  logic       rx_pending;
  logic       div_pending;
  logic       div_fresh;
  logic [7:0] div_latched;
  logic       rr;
  logic [7:0] tmo_cnt;

  logic       div_want;
  logic       rx_want;
  logic [7:0] div_next_value;
  logic       pick_div;
  logic       pick_tx;
  logic       pick_rx;

  // Same-cycle pulses are visible to the arbiter so a load arriving in IDLE still wins.
  assign div_want       = div_pending | div_load;
  assign rx_want        = rx_pending | rx_req;
  assign div_next_value = div_load ? div_value : div_latched;

  always_comb begin
    pick_div = 1'b0;
    pick_tx  = 1'b0;
    pick_rx  = 1'b0;
    if (state == S_IDLE) begin
      if (div_want) begin
        pick_div = 1'b1;
      end else if (tx_valid && rx_want) begin
        if (rr) pick_rx = 1'b1;
        else    pick_tx = 1'b1;
      end else if (tx_valid) begin
        pick_tx = 1'b1;
      end else if (rx_want) begin
        pick_rx = 1'b1;
      end
    end
  end

  // div_fresh marks a load that arrived after the current DIV cycle was chosen,
  // so finishing that cycle must not discard it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_pending  <= 1'b0;
      div_pending <= 1'b0;
      div_fresh   <= 1'b0;
      div_latched <= 8'h00;
    end else begin
      if (div_load) div_latched <= div_value;

      if (pick_div)      div_fresh <= 1'b0;
      else if (div_load) div_fresh <= 1'b1;

      if (state == S_DONE && kind == K_DIV) div_pending <= div_fresh | div_load;
      else if (div_load)                    div_pending <= 1'b1;

      if (state == S_DONE && kind == K_RX) rx_pending <= rx_req;
      else if (rx_req)                     rx_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      kind        <= K_INIT;
      wb.wb_stb   <= 1'b0;
      wb.wb_clk   <= 1'b0;
      wb.wb_we    <= 1'b1;
      wb.wb_addr  <= 2'd0;
      wb.wb_dout  <= 8'h00;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      rr          <= 1'b0;
      tmo_cnt     <= 8'h00;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        S_INIT: begin
          kind       <= K_INIT;
          wb.wb_addr <= 2'd2;
          wb.wb_dout <= RESET_DIV_B;
          wb.wb_we   <= 1'b0;
          wb.wb_stb  <= 1'b1;
          wb.wb_clk  <= 1'b0;
          busy       <= 1'b1;
          state      <= S_SETUP;
        end

        S_IDLE: begin
          busy <= 1'b0;
          if (pick_div) begin
            kind       <= K_DIV;
            wb.wb_addr <= 2'd2;
            wb.wb_dout <= div_next_value;
            wb.wb_we   <= 1'b0;
          end else if (pick_tx) begin
            kind       <= K_TX;
            wb.wb_addr <= 2'd0;
            wb.wb_dout <= tx_data;
            wb.wb_we   <= 1'b0;
            tx_ready   <= 1'b1;
          end else if (pick_rx) begin
            kind       <= K_RX;
            wb.wb_addr <= 2'd1;
            wb.wb_we   <= 1'b1;
          end
          if (pick_div || pick_tx || pick_rx) begin
            wb.wb_stb <= 1'b1;
            wb.wb_clk <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          wb.wb_clk <= 1'b1;
          tmo_cnt   <= 8'h00;
          state     <= S_STROBE;
        end

        S_STROBE: begin
          if (wb.wb_ack) begin
            if (kind == K_RX) rx_data <= wb.wb_din;
            wb.wb_clk <= 1'b0;
            tmo_cnt   <= 8'h00;
            state     <= S_RELEASE;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            wb.wb_clk   <= 1'b0;
            wb.wb_stb   <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_RELEASE: begin
          if (!wb.wb_ack) begin
            wb.wb_stb <= 1'b0;
            rx_valid  <= (kind == K_RX);
            state     <= S_DONE;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            wb.wb_stb   <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_DONE: begin
          if (kind == K_TX || kind == K_RX) rr <= ~rr;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
